// File: rtl/qam_tick_sched_if.sv
// Bit-source handshake and symbol/strobe bus between the 16QAM scheduler and its neighbours.
interface qam_tick_sched_if;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       sample_tick;
  logic [3:0] sym_data;
  logic       sym_load;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, sample_tick, sym_data, sym_load
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, sample_tick, sym_data, sym_load
  );
endinterface

// File: rtl/qam_tick_sched.sv
// 16QAM symbol-rate scheduler: packs 4 source bits per symbol, divides orgin_clk into sample
// strobes and issues one symbol every SPS strobes for a frame of frame_len symbols.
module qam_tick_sched #(
  parameter int DIV   = 10,
  parameter int SPS   = 8,
  parameter int LEN_W = 8
) (
  input  logic             orgin_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  qam_tick_sched_if.slave  sif,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SPS_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SPS_W-1:0] SPS_LAST = SPS_W'(SPS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [LEN_W-1:0] fetch_q, fetch_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SPS_W-1:0] samp_cnt_q, samp_cnt_d;
  logic             sample_tick_q, sample_tick_d;
  logic [3:0]       sym_data_q, sym_data_d;
  logic             sym_load_q, sym_load_d;
  logic             done_q, done_d;
  logic             underflow_q, underflow_d;
  logic             bit_ready;
  logic             xfer;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pcnt_d        = pcnt_q;
    fetch_d       = fetch_q;
    left_d        = left_q;
    div_cnt_d     = div_cnt_q;
    samp_cnt_d    = samp_cnt_q;
    sample_tick_d = 1'b0;
    sym_data_d    = sym_data_q;
    sym_load_d    = 1'b0;
    done_d        = 1'b0;
    underflow_d   = underflow_q;

    case (state_q)
      FILL:    bit_ready = 1'b1;
      RUN:     bit_ready = (pcnt_q != 3'd4) && (fetch_q != '0);
      default: bit_ready = 1'b0;
    endcase
    xfer = sif.bit_valid && bit_ready;

    if (xfer) begin
      pend_d = {pend_q[2:0], sif.bit_in};
      pcnt_d = pcnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          underflow_d = 1'b0;
          if (frame_len != '0) begin
            fetch_d = frame_len;
            left_d  = frame_len;
            pend_d  = '0;
            pcnt_d  = '0;
            state_d = FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (xfer && pcnt_q == 3'd3) begin
          fetch_d    = fetch_q - LEN_W'(1);
          div_cnt_d  = '0;
          samp_cnt_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (xfer && pcnt_q == 3'd3) fetch_d = fetch_q - LEN_W'(1);
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d     = '0;
          sample_tick_d = 1'b1;
          samp_cnt_d    = (samp_cnt_q == SPS_LAST) ? '0 : samp_cnt_q + SPS_W'(1);
          // Symbol boundary: hand over a complete symbol or abort the frame.
          if (samp_cnt_q == '0) begin
            if (pcnt_q == 3'd4) begin
              sym_data_d = pend_q;
              sym_load_d = 1'b1;
              pcnt_d     = '0;
              left_d     = left_q - LEN_W'(1);
            end else begin
              underflow_d = 1'b1;
              done_d      = 1'b1;
              pend_d      = '0;
              pcnt_d      = '0;
              state_d     = IDLE;
            end
          end else if (samp_cnt_q == SPS_LAST && left_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge orgin_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      pcnt_q        <= '0;
      fetch_q       <= '0;
      left_q        <= '0;
      div_cnt_q     <= '0;
      samp_cnt_q    <= '0;
      sample_tick_q <= 1'b0;
      sym_data_q    <= '0;
      sym_load_q    <= 1'b0;
      done_q        <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pcnt_q        <= pcnt_d;
      fetch_q       <= fetch_d;
      left_q        <= left_d;
      div_cnt_q     <= div_cnt_d;
      samp_cnt_q    <= samp_cnt_d;
      sample_tick_q <= sample_tick_d;
      sym_data_q    <= sym_data_d;
      sym_load_q    <= sym_load_d;
      done_q        <= done_d;
      underflow_q   <= underflow_d;
    end
  end

  assign sif.bit_ready   = bit_ready;
  assign sif.sample_tick = sample_tick_q;
  assign sif.sym_data    = sym_data_q;
  assign sif.sym_load    = sym_load_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_qam_tick_sched.sv
// Directed bench for qam_tick_sched: queue-fed bit source, negedge monitor, hand-computed expectations.
module tb_qam_tick_sched;
  localparam int DIV = 10;
  localparam int SPS = 8;

  logic       orgin_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       busy, done, underflow;

  qam_tick_sched_if bif();

  qam_tick_sched #(.DIV(DIV), .SPS(SPS), .LEN_W(8)) dut (
    .orgin_clk (orgin_clk),
    .reset_n   (reset_n),
    .start     (start),
    .frame_len (frame_len),
    .sif       (bif.slave),
    .busy      (busy),
    .done      (done),
    .underflow (underflow)
  );

  always #5 orgin_clk = ~orgin_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge orgin_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bit source: pops one bit per accepted handshake, optionally valid every other cycle.
  logic q_bits[$];
  logic bp_mode = 1'b0;
  logic phase   = 1'b0;
  logic xfer_pend = 1'b0;
  int   acc_cnt = 0;
  logic e0_set = 1'b0;
  int   e0_cyc = 0;

  initial begin
    bif.bit_valid = 1'b0;
    bif.bit_in    = 1'b0;
    forever begin
      @(negedge orgin_clk);
      if (xfer_pend && q_bits.size() > 0) begin
        void'(q_bits.pop_front());
        acc_cnt++;
      end
      phase = ~phase;
      if (q_bits.size() > 0 && (!bp_mode || phase)) begin
        bif.bit_valid = 1'b1;
        bif.bit_in    = q_bits[0];
      end else begin
        bif.bit_valid = 1'b0;
      end
      #1;
      xfer_pend = bif.bit_valid && bif.bit_ready && reset_n;
      if (xfer_pend && acc_cnt == 3 && !e0_set) begin
        e0_set = 1'b1;
        e0_cyc = cyc + 1;
      end
    end
  end

  int         tick_cnt, per_err, first_tick_cyc, last_tick_cyc;
  int         ld_cnt, ld_off, done_cnt, done_tick;
  logic       done_on_tick, done_busy;
  int         ld_tick [8];
  logic [3:0] ld_dat  [8];

  initial begin
    forever begin
      @(negedge orgin_clk);
      if (bif.sample_tick) begin
        tick_cnt++;
        if (tick_cnt == 1) first_tick_cyc = cyc;
        else if (cyc - last_tick_cyc != DIV) per_err++;
        last_tick_cyc = cyc;
      end
      if (bif.sym_load) begin
        if (ld_cnt < 8) begin
          ld_tick[ld_cnt] = tick_cnt;
          ld_dat[ld_cnt]  = bif.sym_data;
        end
        ld_cnt++;
        if (!bif.sample_tick) ld_off++;
      end
      if (done) begin
        done_cnt++;
        done_tick    = tick_cnt;
        done_on_tick = bif.sample_tick;
        done_busy    = busy;
      end
    end
  end

  task automatic clr_mon();
    tick_cnt = 0; per_err = 0; first_tick_cyc = 0; last_tick_cyc = 0;
    ld_cnt = 0; ld_off = 0; done_cnt = 0; done_tick = 0;
    done_on_tick = 1'b0; done_busy = 1'b0;
    acc_cnt = 0; e0_set = 1'b0; e0_cyc = 0;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) q_bits.push_back(v[i]);
  endtask

  task automatic start_frame(input logic [7:0] len);
    @(negedge orgin_clk);
    start = 1'b1;
    frame_len = len;
    @(negedge orgin_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge orgin_clk);
      #2;
      k++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_ready"},   {31'd0, bif.bit_ready},   32'd0);
    chk({tag, "_sample_tick"}, {31'd0, bif.sample_tick}, 32'd0);
    chk({tag, "_sym_data"},    {28'd0, bif.sym_data},    32'd0);
    chk({tag, "_sym_load"},    {31'd0, bif.sym_load},    32'd0);
    chk({tag, "_busy"},        {31'd0, busy},            32'd0);
    chk({tag, "_done"},        {31'd0, done},            32'd0);
    chk({tag, "_underflow"},   {31'd0, underflow},       32'd0);
  endtask

  initial begin
    clr_mon();
    repeat (3) @(negedge orgin_clk);
    #2;
    chk_all_zero("rst");
    @(negedge orgin_clk);
    reset_n = 1'b1;
    @(negedge orgin_clk);
    #2;
    chk("rst_rel_busy", {31'd0, busy}, 32'd0);

    // Normal 2-symbol frame: 1011 0110.
    clr_mon();
    push_bits(32'b1011_0110, 8);
    start_frame(8'd2);
    wait_done(400);
    chk("nrm_ticks", tick_cnt, 32'd16);
    chk("nrm_period", per_err, 32'd0);
    chk("nrm_first_tick", first_tick_cyc - e0_cyc, DIV);
    chk("nrm_loads", ld_cnt, 32'd2);
    chk("nrm_ld0_tick", ld_tick[0], 32'd1);
    chk("nrm_ld0_dat", {28'd0, ld_dat[0]}, 32'hB);
    chk("nrm_ld1_tick", ld_tick[1], 32'd9);
    chk("nrm_ld1_dat", {28'd0, ld_dat[1]}, 32'h6);
    chk("nrm_ld_on_tick", ld_off, 32'd0);
    chk("nrm_done_tick", done_tick, 32'd16);
    chk("nrm_done_with_tick", {31'd0, done_on_tick}, 32'd1);
    chk("nrm_done_busy", {31'd0, done_busy}, 32'd0);
    chk("nrm_underflow", {31'd0, underflow}, 32'd0);
    repeat (3) @(negedge orgin_clk);
    #2;
    chk("nrm_hold_dat", {28'd0, bif.sym_data}, 32'h6);
    chk("nrm_idle_ready", {31'd0, bif.bit_ready}, 32'd0);
    chk("nrm_done_pulses", done_cnt, 32'd1);

    // Zero length frame.
    clr_mon();
    start_frame(8'd0);
    #2;
    chk("zl_done", {31'd0, done}, 32'd1);
    chk("zl_busy", {31'd0, busy}, 32'd0);
    chk("zl_ready", {31'd0, bif.bit_ready}, 32'd0);
    @(negedge orgin_clk);
    #2;
    chk("zl_done_pulse", {31'd0, done}, 32'd0);
    chk("zl_busy2", {31'd0, busy}, 32'd0);

    // Underflow: 3 symbols requested, only 6 bits supplied.
    clr_mon();
    push_bits(32'b1010_11, 6);
    start_frame(8'd3);
    wait_done(400);
    chk("uf_ticks", tick_cnt, 32'd9);
    chk("uf_done_tick", done_tick, 32'd9);
    chk("uf_loads", ld_cnt, 32'd1);
    chk("uf_ld0_dat", {28'd0, ld_dat[0]}, 32'hA);
    chk("uf_flag", {31'd0, underflow}, 32'd1);
    chk("uf_done_busy", {31'd0, done_busy}, 32'd0);
    repeat (2) @(negedge orgin_clk);
    #2;
    chk("uf_sticky", {31'd0, underflow}, 32'd1);
    chk("uf_idle", {31'd0, busy}, 32'd0);
    clr_mon();
    push_bits(32'b0101, 4);
    start_frame(8'd1);
    #2;
    chk("uf_clear", {31'd0, underflow}, 32'd0);
    wait_done(400);
    chk("uf_next_ticks", tick_cnt, 32'd8);
    chk("uf_next_dat", {28'd0, ld_dat[0]}, 32'h5);

    // Source backpressure during FILL.
    clr_mon();
    bp_mode = 1'b1;
    push_bits(32'b1100, 4);
    start_frame(8'd1);
    wait_done(400);
    bp_mode = 1'b0;
    chk("bp_e0_seen", {31'd0, e0_set}, 32'd1);
    chk("bp_first_tick", first_tick_cyc - e0_cyc, DIV);
    chk("bp_ticks", tick_cnt, 32'd8);
    chk("bp_dat", {28'd0, ld_dat[0]}, 32'hC);

    // start during RUN is ignored.
    clr_mon();
    push_bits(32'b0011_1001, 8);
    start_frame(8'd2);
    repeat (40) @(negedge orgin_clk);
    start = 1'b1;
    frame_len = 8'd5;
    @(negedge orgin_clk);
    start = 1'b0;
    wait_done(400);
    chk("sr_ticks", tick_cnt, 32'd16);
    chk("sr_loads", ld_cnt, 32'd2);
    chk("sr_ld1_dat", {28'd0, ld_dat[1]}, 32'h9);
    chk("sr_period", per_err, 32'd0);
    repeat (3) @(negedge orgin_clk);
    #2;
    chk("sr_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN.
    clr_mon();
    push_bits(32'b1110_0001, 8);
    start_frame(8'd2);
    repeat (30) @(negedge orgin_clk);
    #2;
    chk("mr_pre_dat", {28'd0, bif.sym_data}, 32'hE);
    chk("mr_pre_busy", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    q_bits.delete();
    xfer_pend = 1'b0;
    #1;
    chk_all_zero("mr");
    repeat (3) @(negedge orgin_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge orgin_clk);
    #2;
    chk("mr_post_busy", {31'd0, busy}, 32'd0);
    chk("mr_post_ready", {31'd0, bif.bit_ready}, 32'd0);
    chk("mr_no_done", done_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
